collision_detector: RTL
=======================

COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 Parameter CURSOR_W, default 16: pointer hit-box width in pixels.
REQ-002 Parameter CURSOR_H, default 16: pointer hit-box height in pixels.
REQ-003 Parameter LIVES_INIT, default 3: lives loaded at game start (1..7).
REQ-004 Parameter INVULN_FRAMES, default 60: frames of immunity after a hit (1..255).
REQ-005 Port: pclk  input  1  pixel clock; the block has one clock and all state is on its rising edge.
REQ-006 Port: rst  input  1  asynchronous reset, active-low.
REQ-007 Port: game_on  input  1  level; game round active.
REQ-008 Port: vsync_in  input  1  vertical sync from the obstacle pipeline; rising edge marks end of frame.
REQ-009 Port: obstacle_x  input  12  obstacle pixel x; the pair obstacle_x=obstacle_y=0 means no obstacle pixel.
REQ-010 Port: obstacle_y  input  12  obstacle pixel y.
REQ-011 Port: mouse_xpos  input  12  pointer top-left x.
REQ-012 Port: mouse_ypos  input  12  pointer top-left y.
REQ-013 Port: hit  output  1  one-cycle pulse per life lost.
REQ-014 Port: lives  output  3  remaining lives.
REQ-015 Port: invuln  output  1  level; immunity active.
REQ-016 Port: game_over  output  1  level; lives exhausted.

Function
REQ-017 Overlap SHALL be valid pixel AND mouse_xpos <= obstacle_x < mouse_xpos+CURSOR_W AND mouse_ypos <= obstacle_y < mouse_ypos+CURSOR_H, with sums computed in 13 bits (no wrap).
REQ-018 Overlap SHALL be registered (overlap_r), giving one cycle of latency from inputs.
REQ-019 Frame edge SHALL be a registered rising-edge detect of vsync_in (frame_tick, one cycle wide).
REQ-020 Sticky flag SHALL set on overlap_r and clear on frame_tick; an overlap_r asserted in the frame_tick cycle SHALL count toward the ending frame.
REQ-021 FSM states: IDLE, ARMED, INVULN, OVER.
REQ-022 IDLE: lives=LIVES_INIT, sticky cleared; game_on=1 -> ARMED next cycle.
REQ-023 ARMED: on frame_tick with sticky (or overlap_r) set, hit=1 for that cycle and lives decrements by 1; if lives was 1 -> OVER, else -> INVULN with frame counter=INVULN_FRAMES.
REQ-024 INVULN: invuln=1; overlaps ignored; counter decrements on each frame_tick; the frame_tick on which the counter is 1 -> ARMED.
REQ-025 OVER: game_over=1, lives=0; remain until game_on=0 -> IDLE.
REQ-026 game_on=0 in ARMED or INVULN SHALL force IDLE next cycle, with priority over a simultaneous hit (no hit pulse, no decrement).
REQ-027 At most one hit SHALL occur per frame regardless of overlapping pixel count.
REQ-028 lives SHALL never underflow below 0.

Reset
REQ-029 While rst=0: state=IDLE, lives=LIVES_INIT, hit=0, invuln=0, game_over=0, sticky=0, overlap_r=0, counter=0, vsync history=0.
REQ-030 Reset asserted mid-round SHALL abandon the round immediately; after release the block SHALL behave as after power-up.

Configuration
REQ-031 Macro COLLISION_INVULN_EN: when defined, INVULN state and counter are present as specified.
REQ-032 When COLLISION_INVULN_EN is undefined, ARMED SHALL return to ARMED after a non-final hit, counter logic SHALL be absent, and invuln SHALL be tied 0.

Structure
REQ-033 Shared package game_pkg SHALL hold the FSM state encoding, the lives width (3) and the default cursor dimensions.
REQ-034 Sub-module edge_detect (registered rising-edge detector) SHALL produce frame_tick.

Verification
REQ-035 Pointer at (400,400), obstacle pixel (405,410) during one frame -> one hit pulse at next vsync rise, lives 3->2, invuln=1.
REQ-036 Obstacle pixel (416,400) with pointer at (400,400) -> no hit (right boundary exclusive); (415,415) -> hit.
REQ-037 200 overlapping pixels in one frame -> exactly one hit pulse; further overlaps during the next 60 frames -> no hit; invuln drops at the 60th vsync rise.
REQ-038 Three hits separated by immunity -> lives 0, game_over=1; game_on=0 -> IDLE, lives=3 next cycle.
REQ-039 game_on falls in the same cycle as a hit-qualifying frame_tick -> no hit, state IDLE, lives=3.
REQ-040 Build without COLLISION_INVULN_EN: hits in consecutive frames -> lives 3,2,1,0 on successive vsync rises, invuln constant 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the pointer/obstacle collision logic.
// Holds FSM encoding, lives width and default cursor hit-box size.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_INVULN = 2'd2,
      ST_OVER   = 2'd3
   } state_t;

   localparam int LIVES_W      = 3;
   localparam int CNT_W        = 8;
   localparam int CURSOR_W_DEF = 16;
   localparam int CURSOR_H_DEF = 16;

   // lo <= v < lo+len, sum widened to 13 bits so it never wraps
   function automatic logic in_span(
      input logic [11:0] lo,
      input logic [11:0] v,
      input int          len
   );
      logic [12:0] hi;
      hi = {1'b0, lo} + 13'(len);
      return (v >= lo) && ({1'b0, v} < hi);
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector; rise is one cycle wide and
// appears the cycle after sig is first sampled high.
module edge_detect (
   input  logic pclk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic sig_q;

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         sig_q <= 1'b0;
         rise  <= 1'b0;
      end else begin
         sig_q <= sig;
         rise  <= sig & ~sig_q;
      end
   end

endmodule

// File: rtl/collision_detector.sv
// Pointer/obstacle collision, per-frame hit and lives tracking.
// Immunity after a hit is built only when COLLISION_INVULN_EN is defined.
module collision_detector
   import game_pkg::*;
#(
   parameter int CURSOR_W      = CURSOR_W_DEF,
   parameter int CURSOR_H      = CURSOR_H_DEF,
   parameter int LIVES_INIT    = 3,
   parameter int INVULN_FRAMES = 60
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic               game_on,
   input  logic               vsync_in,
   input  logic [11:0]        obstacle_x,
   input  logic [11:0]        obstacle_y,
   input  logic [11:0]        mouse_xpos,
   input  logic [11:0]        mouse_ypos,
   output logic               hit,
   output logic [LIVES_W-1:0] lives,
   output logic               invuln,
   output logic               game_over
);

   localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

   if (LIVES_INIT < 1 || LIVES_INIT > 7) begin : g_bad_lives
      $error("LIVES_INIT out of range");
   end
   if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_frames
      $error("INVULN_FRAMES out of range");
   end

   state_t             state, state_nx;
   logic [LIVES_W-1:0] lives_q, lives_nx;
   logic               overlap_c, overlap_r;
   logic               frame_tick;
   logic               sticky;
   logic               hit_c;
   logic               struck;

   assign overlap_c = (|{obstacle_x, obstacle_y})
                    && in_span(mouse_xpos, obstacle_x, CURSOR_W)
                    && in_span(mouse_ypos, obstacle_y, CURSOR_H);

   edge_detect u_vs_edge (
      .pclk (pclk),
      .rst  (rst),
      .sig  (vsync_in),
      .rise (frame_tick)
   );

   // an overlap landing on the tick cycle still belongs to the old frame
   assign struck = frame_tick && (sticky || overlap_r);

`ifdef COLLISION_INVULN_EN
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INVULN_FRAMES);
   logic [CNT_W-1:0] cnt_q, cnt_nx;
`endif

   always_comb begin
      state_nx = state;
      lives_nx = lives_q;
      hit_c    = 1'b0;
`ifdef COLLISION_INVULN_EN
      cnt_nx   = cnt_q;
`endif
      unique case (state)
         ST_IDLE: begin
            if (game_on) state_nx = ST_ARMED;
         end
         ST_ARMED: begin
            if (!game_on) begin
               state_nx = ST_IDLE;
            end else if (struck) begin
               hit_c = 1'b1;
               if (lives_q <= LIVES_W'(1)) begin
                  lives_nx = '0;
                  state_nx = ST_OVER;
               end else begin
                  lives_nx = lives_q - LIVES_W'(1);
`ifdef COLLISION_INVULN_EN
                  state_nx = ST_INVULN;
                  cnt_nx   = CNT_INIT;
`endif
               end
            end
         end
         ST_INVULN: begin
`ifdef COLLISION_INVULN_EN
            if (!game_on) begin
               state_nx = ST_IDLE;
            end else if (frame_tick) begin
               if (cnt_q == CNT_W'(1)) begin
                  state_nx = ST_ARMED;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_q - CNT_W'(1);
               end
            end
`else
            state_nx = ST_IDLE;
`endif
         end
         ST_OVER: begin
            lives_nx = '0;
            if (!game_on) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (state_nx == ST_IDLE) begin
         lives_nx = LIVES_RST;
`ifdef COLLISION_INVULN_EN
         cnt_nx   = '0;
`endif
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         lives_q   <= LIVES_RST;
         overlap_r <= 1'b0;
         sticky    <= 1'b0;
      end else begin
         state     <= state_nx;
         lives_q   <= lives_nx;
         overlap_r <= overlap_c;
         if (state == ST_IDLE || frame_tick)
            sticky <= 1'b0;
         else if (overlap_r)
            sticky <= 1'b1;
      end
   end

`ifdef COLLISION_INVULN_EN
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_nx;
   end

   assign invuln = (state == ST_INVULN);
`else
   assign invuln = 1'b0;
`endif

   assign hit       = hit_c;
   assign lives     = lives_q;
   assign game_over = (state == ST_OVER);

endmodule
